// File: rtl/hash_target_checker.sv
// Tracks issued nonces through a delay line matched to the hash core latency and
// reports the first nonce whose hash is strictly below the difficulty target.
module hash_target_checker #(
  parameter int unsigned HASH_W  = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic [31:0]       nonce_in,
  input  logic              nonce_valid,
  input  logic [HASH_W-1:0] hash_in,
  input  logic              hash_valid,
  input  logic [HASH_W-1:0] target,
  output logic              terminado,
  output logic              encontrado,
  output logic [31:0]       nonce_ganador,
  output logic [31:0]       intentos,
  output logic              error_alineacion
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned SLOT_W  = NONCE_W + 1;
  localparam int unsigned PIPE_W  = SLOT_W * LATENCY;
  localparam logic [NONCE_W-1:0] NONCE_LAST = {NONCE_W{1'b1}};
  localparam logic [NONCE_W-1:0] CNT_MAX    = {NONCE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [NONCE_W-1:0] nonce;
  } slot_t;

  state_e             state_q, state_d;
  logic [PIPE_W-1:0]  pipe_q, pipe_d;
  logic               term_q, term_d;
  logic               enc_q, enc_d;
  logic               err_q, err_d;
  logic [NONCE_W-1:0] win_q, win_d;
  logic [NONCE_W-1:0] cnt_q, cnt_d;

  slot_t              new_slot;
  slot_t              tail;
  logic               hit;

  // Oldest slot of the delay line is the nonce whose hash is on hash_in now.
  assign new_slot = slot_t'({nonce_valid, nonce_in});
  assign tail     = slot_t'(pipe_q[PIPE_W-1 -: SLOT_W]);
  assign hit      = hash_in < target;

  always_comb begin
    state_d = state_q;
    pipe_d  = pipe_q;
    term_d  = term_q;
    enc_d   = enc_q;
    err_d   = err_q;
    win_d   = win_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        pipe_d = '0;
        term_d = 1'b0;
        enc_d  = 1'b0;
        if (inicio) begin
          state_d = S_SEARCH;
          cnt_d   = '0;
          win_d   = '0;
          err_d   = 1'b0;
        end
      end

      S_SEARCH: begin
        if (!inicio) begin
          state_d = S_IDLE;
          pipe_d  = '0;
          term_d  = 1'b0;
          enc_d   = 1'b0;
        end else begin
          pipe_d = PIPE_W'({pipe_q, new_slot});
          if (tail.valid != hash_valid) begin
            err_d = 1'b1;
          end else if (tail.valid) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + NONCE_W'(1);
            // A hit on the last nonce still reports as found.
            if (hit) begin
              win_d   = tail.nonce;
              enc_d   = 1'b1;
              term_d  = 1'b1;
              state_d = S_DONE;
              pipe_d  = '0;
            end else if (tail.nonce == NONCE_LAST) begin
              enc_d   = 1'b0;
              term_d  = 1'b1;
              state_d = S_DONE;
              pipe_d  = '0;
            end
          end
        end
      end

      S_DONE: begin
        pipe_d = '0;
        if (!inicio) begin
          state_d = S_IDLE;
          term_d  = 1'b0;
          enc_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        pipe_d  = '0;
        term_d  = 1'b0;
        enc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pipe_q  <= '0;
      term_q  <= 1'b0;
      enc_q   <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      term_q  <= term_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign terminado        = term_q;
  assign encontrado       = enc_q;
  assign nonce_ganador    = win_q;
  assign intentos         = cnt_q;
  assign error_alineacion = err_q;

endmodule

// File: tb/tb_hash_target_checker.sv
// Self-checking bench: a hash-core stand-in schedules results LATENCY cycles after
// each issued nonce; a cycle-history reference model predicts every output.
module tb_hash_target_checker;

  localparam int unsigned HW  = 256;
  localparam int          LAT = 4;

  logic          clk, reset, inicio, nonce_valid, hash_valid;
  logic [31:0]   nonce_in;
  logic [HW-1:0] hash_in, target;
  logic          terminado, encontrado, error_alineacion;
  logic [31:0]   nonce_ganador, intentos;

  hash_target_checker #(.HASH_W(HW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .inicio(inicio),
    .nonce_in(nonce_in), .nonce_valid(nonce_valid),
    .hash_in(hash_in), .hash_valid(hash_valid), .target(target),
    .terminado(terminado), .encontrado(encontrado),
    .nonce_ganador(nonce_ganador), .intentos(intentos),
    .error_alineacion(error_alineacion)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 searching, 2 finished.
  int          m_phase = 0;
  int          m_start = 0;
  bit          m_term = 0, m_enc = 0, m_err = 0;
  logic [31:0] m_win = '0, m_cnt = '0;
  bit          iss_v[int];
  logic [31:0] iss_n[int];
  bit          sch_v[int];
  logic [HW-1:0] sch_h[int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit          tv;
    logic [31:0] tn;
    if (reset) begin
      m_phase = 0; m_term = 0; m_enc = 0; m_err = 0; m_win = '0; m_cnt = '0;
      return;
    end
    case (m_phase)
      0: if (inicio) begin
        m_phase = 1; m_cnt = '0; m_win = '0; m_err = 0; m_start = cyc + 1;
      end
      1: if (!inicio) begin
        m_phase = 0;
      end else begin
        if (nonce_valid) begin
          iss_v[cyc] = 1'b1;
          iss_n[cyc] = nonce_in;
        end
        tv = 1'b0;
        tn = '0;
        if (cyc - LAT >= m_start && iss_v.exists(cyc - LAT)) begin
          tv = 1'b1;
          tn = iss_n[cyc - LAT];
        end
        if (tv != hash_valid) m_err = 1'b1;
        else if (tv) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
          if (hash_in < target) begin
            m_win = tn; m_enc = 1'b1; m_term = 1'b1; m_phase = 2;
          end else if (tn == 32'hFFFF_FFFF) begin
            m_enc = 1'b0; m_term = 1'b1; m_phase = 2;
          end
        end
      end
      2: if (!inicio) begin
        m_phase = 0; m_term = 1'b0; m_enc = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("terminado", 32'(terminado), 32'(m_term));
    chk("encontrado", 32'(encontrado), 32'(m_enc));
    chk("intentos", intentos, m_cnt);
    chk("error_alineacion", 32'(error_alineacion), 32'(m_err));
    if (m_enc) chk("nonce_ganador", nonce_ganador, m_win);
  endtask

  // One clock cycle: present inputs, advance model, check after the edge.
  task automatic drive(input bit nv, input logic [31:0] n, input logic [HW-1:0] h, input bit inj);
    nonce_valid = nv;
    nonce_in    = n;
    if (nv) begin
      sch_v[cyc + LAT] = 1'b1;
      sch_h[cyc + LAT] = h;
    end
    if (sch_v.exists(cyc)) begin
      hash_valid = 1'b1;
      hash_in    = sch_h[cyc];
    end else begin
      hash_valid = 1'b0;
      hash_in    = HW'({8{$urandom}});
    end
    if (inj) hash_valid = ~hash_valid;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    inicio = 1'b0;
    repeat (n) drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic start();
    inicio = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_term(input int max_cyc, output int waited);
    waited = 0;
    while (!terminado && waited < max_cyc) begin
      drive(1'b0, '0, '0, 1'b0);
      waited++;
    end
    chk("wait_terminado", 32'(terminado), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            w;
    logic [31:0]   n;
    logic [HW-1:0] t;
    bit            exh, nv;

    reset = 1'b1; inicio = 1'b0; nonce_valid = 1'b0; nonce_in = '0;
    hash_valid = 1'b0; hash_in = '0; target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_terminado", 32'(terminado), 32'd0);
    chk("reset_encontrado", 32'(encontrado), 32'd0);
    chk("reset_intentos", intentos, 32'd0);
    chk("reset_ganador", nonce_ganador, 32'd0);
    chk("reset_error", 32'(error_alineacion), 32'd0);
    reset = 1'b0;
    idle(2);

    // Reset with three nonces in flight, then a fresh search counts from zero
    target = HW'(1000);
    start();
    for (int k = 0; k < 3; k++) drive(1'b1, 32'(10 + k), '1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_terminado", 32'(terminado), 32'd0);
    chk("midreset_intentos", intentos, 32'd0);
    chk("midreset_error", 32'(error_alineacion), 32'd0);
    model_update();
    inicio = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    idle(LAT + 2);
    start();
    drive(1'b1, 32'd20, '1, 1'b0);
    drive(1'b1, 32'd21, '1, 1'b0);
    repeat (LAT) drive(1'b0, '0, '0, 1'b0);
    chk("restart_intentos", intentos, 32'd2);
    idle(LAT + 2);

    // Nonces 0..9 with hash 1000-n against 995: nonce 6 wins
    target = HW'(995);
    start();
    for (int k = 0; k < 10; k++) drive(1'b1, 32'(k), HW'(1000 - k), 1'b0);
    wait_term(10, w);
    chk("main_latency", 32'(w), 32'd1);
    chk("main_ganador", nonce_ganador, 32'd6);
    chk("main_intentos", intentos, 32'd7);
    chk("main_encontrado", 32'(encontrado), 32'd1);
    repeat (10) drive(1'b0, '0, '0, 1'b0);
    chk("done_hold_terminado", 32'(terminado), 32'd1);
    chk("done_hold_intentos", intentos, 32'd7);
    inicio = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk("done_exit_terminado", 32'(terminado), 32'd0);
    idle(LAT + 2);

    // Equality is not a hit, one below is
    t = HW'({8{$urandom}}) | HW'(1);
    target = t;
    start();
    drive(1'b1, 32'd100, t, 1'b0);
    drive(1'b1, 32'd101, t - HW'(1), 1'b0);
    wait_term(10, w);
    chk("boundary_latency", 32'(w), 32'd4);
    chk("boundary_ganador", nonce_ganador, 32'd101);
    chk("boundary_intentos", intentos, 32'd2);
    idle(LAT + 2);

    // Exhaustion without and with a hit on the last nonce
    for (int run = 0; run < 2; run++) begin
      start();
      drive(1'b1, 32'hFFFF_FFFD, t, 1'b0);
      drive(1'b1, 32'hFFFF_FFFE, t, 1'b0);
      drive(1'b1, 32'hFFFF_FFFF, (run == 1) ? t - HW'(1) : t, 1'b0);
      wait_term(10, w);
      chk("exh_intentos", intentos, 32'd3);
      chk("exh_encontrado", 32'(encontrado), 32'(run));
      if (run == 1) chk("exh_ganador", nonce_ganador, 32'hFFFF_FFFF);
      idle(LAT + 2);
    end

    // Abort mid-search, then restart
    target = HW'(1000);
    start();
    for (int k = 0; k < 6; k++) drive(1'b1, 32'(200 + k), '1, 1'b0);
    chk("abort_pre_intentos", intentos, 32'd2);
    inicio = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk("abort_terminado", 32'(terminado), 32'd0);
    idle(LAT + 2);
    start();
    chk("abort_restart_intentos", intentos, 32'd0);
    idle(LAT + 2);

    // Spurious hash_valid with an empty pipeline
    target = HW'(100);
    start();
    drive(1'b0, '0, '0, 1'b1);
    chk("misalign_flag", 32'(error_alineacion), 32'd1);
    chk("misalign_intentos", intentos, 32'd0);
    drive(1'b1, 32'd5, HW'(0), 1'b0);
    wait_term(10, w);
    chk("misalign_sticky_done", 32'(error_alineacion), 32'd1);
    idle(LAT + 2);
    chk("misalign_sticky_idle", 32'(error_alineacion), 32'd1);
    start();
    chk("misalign_cleared", 32'(error_alineacion), 32'd0);
    idle(LAT + 2);

    // Randomized searches: gaps, rare aborts, occasional misalignment
    for (int s = 0; s < 12; s++) begin
      target = HW'(500);
      n   = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 25) : $urandom;
      exh = 1'b0;
      start();
      for (int i = 0; i < 80; i++) begin
        if (m_phase != 1) break;
        if ($urandom_range(0, 99) == 0) inicio = 1'b0;
        nv = !exh && ($urandom_range(0, 3) != 0);
        drive(nv, n, HW'($urandom_range(0, 20000)), $urandom_range(0, 39) == 0);
        if (nv) begin
          if (n == 32'hFFFF_FFFF) exh = 1'b1;
          else n = n + 32'd1;
        end
      end
      if (m_phase == 2) repeat ($urandom_range(0, 5)) drive(1'b0, '0, '0, 1'b0);
      idle(LAT + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
